// File: rtl/dmem_arbiter_if.sv
// rtl/dmem_arbiter_if.sv - bus bundle between CPU mem stage, host port, data memory and the arbiter
//
// Purpose : groups every handshake/data signal of the data-memory arbiter so the
//           arbiter takes a single bus port next to its plain clk/rst.
// Modports:
//   master : requester/memory side (drives cpu_*, host_* requests and mem_rdata)
//   slave  : arbiter side (drives grants, read responses, stall and memory strobes)
// Signals :
//   cpu_req/we/addr/wdata/be    CPU request;  cpu_gnt, cpu_rvalid, cpu_rdata, o_stall back
//   host_req/we/addr/wdata/be   host request; host_gnt, host_rvalid, host_rdata back
//   mem_en/we/addr/wdata        memory strobe, byte write mask, address, write data
//   mem_rdata                   memory read data, valid one cycle after mem_en

interface dmem_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) ();
  localparam int BE_W = DATA_W / 8;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [BE_W-1:0]   cpu_be;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              o_stall;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic [BE_W-1:0]   host_be;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    output host_req, host_we, host_addr, host_wdata, host_be,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, o_stall,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be,
    input  host_req, host_we, host_addr, host_wdata, host_be,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, o_stall,
    output host_gnt, host_rvalid, host_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - single-port data memory arbiter, CPU priority with host starvation guard
//
// Purpose : shares the single-port data memory between the CPU mem stage and the
//           host/filter-loader port. The CPU wins by default; after STARVE_LIM cycles
//           of the host losing, the host is granted once. Read data comes back one
//           cycle after the grant, qualified by the owner's rvalid. o_stall freezes the
//           pipeline whenever a CPU request is refused.
// Ports   :
//   clk  in  system clock
//   rst  in  synchronous reset, active-high
//   bus  slave modport of dmem_arbiter_if (CPU, host and memory signals)
// Params  :
//   ADDR_W      word-address width
//   DATA_W      data width (byte enables are DATA_W/8 bits)
//   STARVE_LIM  host lost cycles before a forced host grant (>= 1)

module dmem_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic           clk,
  input  logic           rst,
  dmem_arbiter_if.slave  bus
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

  typedef enum logic [0:0] {
    CPU_PRI  = 1'b0,
    HOST_PRI = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  wait_cnt_nxt;

  logic              cpu_gnt;
  logic              host_gnt;
  logic              cpu_rvalid_q;
  logic              host_rvalid_q;

  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // State register, starvation counter and read-owner tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= CPU_PRI;
      wait_cnt      <= '0;
      cpu_rvalid_q  <= 1'b0;
      host_rvalid_q <= 1'b0;
    end else begin
      state         <= state_nxt;
      wait_cnt      <= wait_cnt_nxt;
      // The owner of a granted read gets rvalid exactly one cycle later.
      cpu_rvalid_q  <= cpu_gnt & ~bus.cpu_we;
      host_rvalid_q <= host_gnt & ~bus.host_we;
    end
  end

  // Grants, next counter value and next state.
  always_comb begin
    cpu_gnt      = 1'b0;
    host_gnt     = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;

    case (state)
      CPU_PRI: begin
        if (bus.cpu_req)       cpu_gnt  = 1'b1;
        else if (bus.host_req) host_gnt = 1'b1;
      end
      HOST_PRI: begin
        if (bus.host_req)      host_gnt = 1'b1;
        else if (bus.cpu_req)  cpu_gnt  = 1'b1;
      end
      default: ;
    endcase

    // Nothing reaches the memory while reset is held.
    if (rst) begin
      cpu_gnt  = 1'b0;
      host_gnt = 1'b0;
    end

    // Count only cycles the host is actually waiting; a withdrawn host request
    // also restarts the count so a stale total cannot force a later grant.
    if (host_gnt || !bus.host_req) begin
      wait_cnt_nxt = '0;
    end else if (wait_cnt != LIM) begin
      wait_cnt_nxt = wait_cnt + CNT_W'(1);
    end

    case (state)
      CPU_PRI: begin
        if (wait_cnt_nxt == LIM) state_nxt = HOST_PRI;
      end
      HOST_PRI: begin
        if (host_gnt || !bus.host_req) state_nxt = CPU_PRI;
      end
      default: state_nxt = CPU_PRI;
    endcase
  end

  // Memory-side mux: winner's fields, all zero when idle.
  always_comb begin
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = bus.cpu_we ? bus.cpu_be : '0;
      mem_addr  = bus.cpu_addr;
      mem_wdata = bus.cpu_wdata;
    end else if (host_gnt) begin
      mem_we    = bus.host_we ? bus.host_be : '0;
      mem_addr  = bus.host_addr;
      mem_wdata = bus.host_wdata;
    end
  end

  assign bus.cpu_gnt     = cpu_gnt;
  assign bus.host_gnt    = host_gnt;
  assign bus.o_stall     = bus.cpu_req & ~cpu_gnt;
  assign bus.cpu_rvalid  = cpu_rvalid_q;
  assign bus.host_rvalid = host_rvalid_q;
  // Both requesters see the raw memory data; rvalid says whose it is.
  assign bus.cpu_rdata   = bus.mem_rdata;
  assign bus.host_rdata  = bus.mem_rdata;
  assign bus.mem_en      = cpu_gnt | host_gnt;
  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = mem_addr;
  assign bus.mem_wdata   = mem_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter

module tb_dmem_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  dmem_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(10), .DATA_W(32), .STARVE_LIM(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here, outputs
  // are sampled #1 later once combinational grants have settled.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req    = 1'b0;
    bus.cpu_we     = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_wdata  = '0;
    bus.cpu_be     = '0;
    bus.host_req   = 1'b0;
    bus.host_we    = 1'b0;
    bus.host_addr  = '0;
    bus.host_wdata = '0;
    bus.host_be    = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    idle_inputs();
    bus.mem_rdata = '0;

    // Reset: grants forced low even with a request present.
    step();
    bus.cpu_req = 1'b1;
    #1;
    check("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    check("rst_mem_en", 32'(bus.mem_en), 32'd0);
    step();
    check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("rst_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    check("rst_state", 32'(dut.state), 32'd0);
    check("rst_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    rst = 1'b0;
    idle_inputs();

    // CPU read of 0x010.
    step();
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = 10'h010;
    bus.mem_rdata = 32'hDEADBEEF;
    #1;
    check("rd_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    check("rd_mem_en", 32'(bus.mem_en), 32'd1);
    check("rd_mem_addr", 32'(bus.mem_addr), 32'h010);
    check("rd_mem_we", 32'(bus.mem_we), 32'd0);
    check("rd_stall", 32'(bus.o_stall), 32'd0);
    step();
    bus.cpu_req = 1'b0;
    #1;
    check("rd_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check("rd_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    check("rd_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    check("idle_mem_addr", 32'(bus.mem_addr), 32'd0);
    step();
    check("rd_rvalid_clear", 32'(bus.cpu_rvalid), 32'd0);

    // Host write, CPU idle.
    bus.host_req   = 1'b1;
    bus.host_we    = 1'b1;
    bus.host_be    = 4'b0011;
    bus.host_wdata = 32'h12345678;
    bus.host_addr  = 10'h020;
    #1;
    check("wr_host_gnt", 32'(bus.host_gnt), 32'd1);
    check("wr_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    check("wr_mem_we", 32'(bus.mem_we), 32'h3);
    check("wr_mem_wdata", bus.mem_wdata, 32'h12345678);
    check("wr_mem_addr", 32'(bus.mem_addr), 32'h020);
    step();
    idle_inputs();
    #1;
    check("wr_no_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    check("wr_no_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);

    // CPU read then host read in consecutive cycles.
    step();
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 10'h005;
    #1;
    check("bb_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    step();
    bus.cpu_req   = 1'b0;
    bus.host_req  = 1'b1;
    bus.host_addr = 10'h006;
    #1;
    check("bb_c1_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check("bb_c1_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    check("bb_c1_host_gnt", 32'(bus.host_gnt), 32'd1);
    check("bb_c1_mem_addr", 32'(bus.mem_addr), 32'h006);
    step();
    bus.host_req  = 1'b0;
    bus.mem_rdata = 32'hCAFEF00D;
    #1;
    check("bb_c2_host_rvalid", 32'(bus.host_rvalid), 32'd1);
    check("bb_c2_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("bb_c2_host_rdata", bus.host_rdata, 32'hCAFEF00D);
    step();
    check("bb_c3_host_rvalid", 32'(bus.host_rvalid), 32'd0);

    // Both requesting continuously: C C C C H, repeated.
    bus.cpu_req   = 1'b1;
    bus.cpu_addr  = 10'h100;
    bus.host_req  = 1'b1;
    bus.host_addr = 10'h200;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("st%0d_cpu_gnt", i), 32'(bus.cpu_gnt), (i % 5 == 4) ? 32'd0 : 32'd1);
      check($sformatf("st%0d_host_gnt", i), 32'(bus.host_gnt), (i % 5 == 4) ? 32'd1 : 32'd0);
      check($sformatf("st%0d_stall", i), 32'(bus.o_stall), (i % 5 == 4) ? 32'd1 : 32'd0);
      check($sformatf("st%0d_wait_cnt", i), 32'(dut.wait_cnt), 32'(i % 5));
      check($sformatf("st%0d_mem_addr", i), 32'(bus.mem_addr), (i % 5 == 4) ? 32'h200 : 32'h100);
      step();
    end

    // Host drops its request just as HOST_PRI is reached.
    for (int i = 0; i < 4; i++) step();
    #1;
    check("drop_state_hpri", 32'(dut.state), 32'd1);
    check("drop_wait_cnt_lim", 32'(dut.wait_cnt), 32'd4);
    bus.host_req = 1'b0;
    #1;
    check("drop_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    check("drop_host_gnt", 32'(bus.host_gnt), 32'd0);
    check("drop_stall", 32'(bus.o_stall), 32'd0);
    step();
    check("drop_state_cpri", 32'(dut.state), 32'd0);
    check("drop_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    check("drop_cpu_gnt2", 32'(bus.cpu_gnt), 32'd1);

    // Reset asserted the cycle after a granted CPU read, host waiting.
    bus.cpu_we   = 1'b0;
    bus.host_req = 1'b1;
    #1;
    check("rr_cpu_gnt", 32'(bus.cpu_gnt), 32'd1);
    step();
    rst = 1'b1;
    #1;
    check("rr_wait_cnt_pre", 32'(dut.wait_cnt), 32'd1);
    check("rr_gnt_forced", 32'(bus.cpu_gnt | bus.host_gnt), 32'd0);
    step();
    check("rr_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("rr_host_rvalid", 32'(bus.host_rvalid), 32'd0);
    check("rr_state", 32'(dut.state), 32'd0);
    check("rr_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    rst = 1'b0;
    idle_inputs();
    step();
    check("rr_post_cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
